// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
// Signed ops 10/11 are enabled by defining MULDIV_SIGNED_EN.
package muldiv_pkg;

   localparam int DATA_W = 32;
   localparam int ITER_N = 32;
   localparam int CNT_W  = 5;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_DIVU  = 2'b01;
   localparam logic [1:0] OP_MULT  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between a requester (master) and muldiv_unit (slave).
interface muldiv_if;
   import muldiv_pkg::*;

   logic              start;
   logic              flush;
   logic [1:0]        op;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic              busy;
   logic              done;
   logic              dz;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;

   modport master (
      output start, flush, op, a, b,
      input  busy, done, dz, hi, lo
   );

   modport slave (
      input  start, flush, op, a, b,
      output busy, done, dz, hi, lo
   );

endinterface

// File: rtl/muldiv_core.sv
// One-bit-per-cycle datapath: 64-bit shift register, shared 33-bit add/subtract
// unit and iteration counter. r_nxt is the register value after the current step.
module muldiv_core
   import muldiv_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                calc_en,
   input  logic                is_div,
   input  logic [DATA_W-1:0]   a_mag,
   input  logic [DATA_W-1:0]   b_mag,
   output logic                last,
   output logic [2*DATA_W-1:0] r_nxt
);

   logic [CNT_W-1:0]    cnt_q;
   logic [2*DATA_W-1:0] r_q;
   logic [DATA_W-1:0]   m_q;
   logic [DATA_W:0]     au_a;
   logic [DATA_W:0]     au_b;
   logic [DATA_W+1:0]   au_sum;
   logic                div_ge;

   // Subtraction is a + ~b + 1; bit DATA_W+1 is then the no-borrow flag.
   always_comb begin
      if (is_div) begin
         au_a = r_q[2*DATA_W-1:DATA_W-1];
         au_b = ~{1'b0, m_q};
      end else begin
         au_a = {1'b0, r_q[2*DATA_W-1:DATA_W]};
         au_b = {1'b0, m_q};
      end
      au_sum = {1'b0, au_a} + {1'b0, au_b} + {{(DATA_W+1){1'b0}}, is_div};
      div_ge = au_sum[DATA_W+1];
   end

   always_comb begin
      if (is_div) begin
         if (div_ge)
            r_nxt = {au_sum[DATA_W-1:0], r_q[DATA_W-2:0], 1'b1};
         else
            r_nxt = {r_q[2*DATA_W-2:0], 1'b0};
      end else begin
         if (r_q[0])
            r_nxt = {au_sum[DATA_W:0], r_q[DATA_W-1:1]};
         else
            r_nxt = {1'b0, r_q[2*DATA_W-1:1]};
      end
   end

   assign last = (cnt_q == CNT_W'(ITER_N - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt_q <= '0;
      else if (load)
         cnt_q <= '0;
      else if (calc_en)
         cnt_q <= cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (load) begin
         r_q <= {{DATA_W{1'b0}}, a_mag};
         m_q <= b_mag;
      end else if (calc_en) begin
         r_q <= r_nxt;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit: FSM, operand capture and HI/LO registers.
// Define MULDIV_SIGNED_EN to give ops 10/11 signed semantics.
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   muldiv_if.slave  bus
);

   state_t              state_q;
   state_t              state_d;
   logic                accept;
   logic                calc_en;
   logic                last;
   logic                wr_res;
   logic                is_div_q;
   logic                bz_q;
   logic                dz_q;
   logic [DATA_W-1:0]   a_q;
   logic [DATA_W-1:0]   a_mag;
   logic [DATA_W-1:0]   b_mag;
   logic [DATA_W-1:0]   base_hi;
   logic [DATA_W-1:0]   base_lo;
   logic [DATA_W-1:0]   hi_q;
   logic [DATA_W-1:0]   lo_q;
   logic [2*DATA_W-1:0] r_nxt;

   assign accept  = (state_q != ST_CALC) && bus.start && !bus.flush;
   assign calc_en = (state_q == ST_CALC) && !bus.flush;
   assign wr_res  = calc_en && last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.start) state_d = ST_CALC;
         ST_CALC: if (last)      state_d = ST_DONE;
         ST_DONE: state_d = bus.start ? ST_CALC : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (bus.flush)
         state_d = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         is_div_q <= bus.op[0];
         a_q      <= bus.a;
         bz_q     <= (bus.b == '0);
      end
   end

`ifdef MULDIV_SIGNED_EN
   logic sgn_op;
   logic neg_quo_q;
   logic neg_rem_q;
   logic signed [DATA_W-1:0]   a_s;
   logic signed [DATA_W-1:0]   b_s;

   function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] x);
      return x[DATA_W-1] ? DATA_W'(-x) : DATA_W'(x);
   endfunction

   function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] x);
      return ~x + 1'b1;
   endfunction

   function automatic logic [2*DATA_W-1:0] neg64(input logic [2*DATA_W-1:0] x);
      return ~x + 1'b1;
   endfunction

   assign sgn_op = bus.op[1];
   assign a_s    = bus.a;
   assign b_s    = bus.b;
   assign a_mag  = sgn_op ? abs_val(a_s) : bus.a;
   assign b_mag  = sgn_op ? abs_val(b_s) : bus.b;

   always_ff @(posedge clk) begin
      if (accept) begin
         neg_quo_q <= sgn_op && (bus.a[DATA_W-1] ^ bus.b[DATA_W-1]);
         neg_rem_q <= sgn_op && bus.a[DATA_W-1];
      end
   end

   // Magnitude result is re-signed here; the remainder follows the dividend.
   always_comb begin
      if (is_div_q) begin
         base_lo = neg_quo_q ? neg32(r_nxt[DATA_W-1:0]) : r_nxt[DATA_W-1:0];
         base_hi = neg_rem_q ? neg32(r_nxt[2*DATA_W-1:DATA_W]) : r_nxt[2*DATA_W-1:DATA_W];
      end else begin
         {base_hi, base_lo} = neg_quo_q ? neg64(r_nxt) : r_nxt;
      end
   end
`else
   assign a_mag   = bus.a;
   assign b_mag   = bus.b;
   assign base_hi = r_nxt[2*DATA_W-1:DATA_W];
   assign base_lo = r_nxt[DATA_W-1:0];
`endif

   muldiv_core u_core (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .calc_en (calc_en),
      .is_div  (is_div_q),
      .a_mag   (a_mag),
      .b_mag   (b_mag),
      .last    (last),
      .r_nxt   (r_nxt)
   );

   // HI/LO change only on the final CALC edge; divide-by-zero overrides the datapath.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_q <= '0;
         lo_q <= '0;
         dz_q <= 1'b0;
      end else if (wr_res) begin
         if (is_div_q && bz_q) begin
            hi_q <= a_q;
            lo_q <= '1;
            dz_q <= 1'b1;
         end else begin
            hi_q <= base_hi;
            lo_q <= base_lo;
            dz_q <= 1'b0;
         end
      end
   end

   assign bus.busy = (state_q == ST_CALC);
   assign bus.done = (state_q == ST_DONE);
   assign bus.dz   = (state_q == ST_DONE) && dz_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table, random ops against a reference model,
// and hand sequences for back-to-back, ignored start, flush and reset.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   muldiv_if bus ();

   muldiv_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      exp_t        e;
   } vec_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   vec_t        tbl[$];
   int          pass_cnt = 0;
   int          chk_cnt  = 0;
   logic [31:0] last_hi  = '0;
   logic [31:0] last_lo  = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic exp_t mk_e(input logic [31:0] hi, input logic [31:0] lo, input logic dz);
      exp_t e;
      e.hi = hi; e.lo = lo; e.dz = dz;
      return e;
   endfunction

   function automatic vec_t mkv(input string n, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] hi,
                                input logic [31:0] lo, input logic dz);
      vec_t v;
      v.name = n; v.op = op; v.a = a; v.b = b; v.e = mk_e(hi, lo, dz);
      return v;
   endfunction

   // Reference behaviour built from native wide arithmetic.
   function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      logic   sg;
      longint sa, sb, q, r, p;
      logic [63:0] up;
`ifdef MULDIV_SIGNED_EN
      sg = op[1];
`else
      sg = 1'b0;
`endif
      e.dz = 1'b0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!op[0]) begin
         if (sg) begin
            p = sa * sb;
            {e.hi, e.lo} = p;
         end else begin
            up = {32'b0, a} * {32'b0, b};
            {e.hi, e.lo} = up;
         end
      end else if (b == 32'd0) begin
         e.hi = a; e.lo = 32'hFFFFFFFF; e.dz = 1'b1;
      end else if (sg) begin
         q = sa / sb;
         r = sa % sb;
         e.lo = q[31:0];
         e.hi = r[31:0];
      end else begin
         e.lo = a / b;
         e.hi = a % b;
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst && bus.done === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check("hi", {32'b0, bus.hi}, {32'b0, mon_e.hi});
            check("lo", {32'b0, bus.lo}, {32'b0, mon_e.lo});
            check("dz", {63'b0, bus.dz}, {63'b0, mon_e.dz});
            last_hi = mon_e.hi;
            last_lo = mon_e.lo;
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input exp_t e, input bit push);
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      if (push) sb_q.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      bus.op = 2'($urandom_range(0, 3));
      bus.a  = $urandom;
      bus.b  = $urandom;
   endtask

   task automatic wait_done(output int nbusy);
      nbusy = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done === 1'b1) return;
         if (bus.busy === 1'b1) nbusy++;
         @(negedge clk);
      end
      check("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic count_done(input int ncyc, output int ndone);
      ndone = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) ndone++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   nb;
      int   nd;
      exp_t e;
      logic [1:0]  rop;
      logic [31:0] ra, rb;

      bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;

      tbl.push_back(mkv("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0));
      tbl.push_back(mkv("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0));
      tbl.push_back(mkv("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1));
      tbl.push_back(mkv("div_by0", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1));
      tbl.push_back(mkv("divu_small", OP_DIVU, 32'd7, 32'd100, 32'd7, 32'd0, 1'b0));
      tbl.push_back(mkv("divu_by1", OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 1'b0));
      tbl.push_back(mkv("multu_zero", OP_MULTU, 32'd0, 32'h12345678, 32'd0, 32'd0, 1'b0));
`ifdef MULDIV_SIGNED_EN
      tbl.push_back(mkv("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0));
      tbl.push_back(mkv("mult_m3_4", OP_MULT, 32'hFFFFFFFD, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFF4, 1'b0));
      tbl.push_back(mkv("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0));
      tbl.push_back(mkv("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0));
      tbl.push_back(mkv("mult_m1_m1", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0));
`else
      tbl.push_back(mkv("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC, 1'b0));
      tbl.push_back(mkv("mult_m3_4", OP_MULT, 32'hFFFFFFFD, 32'd4, 32'h3, 32'hFFFFFFF4, 1'b0));
      tbl.push_back(mkv("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0));
      tbl.push_back(mkv("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd7, 32'd0, 1'b0));
      tbl.push_back(mkv("mult_m1_m1", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0));
`endif

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", {63'b0, bus.busy}, 64'd0);
      check("rst_done", {63'b0, bus.done}, 64'd0);
      check("rst_dz",   {63'b0, bus.dz},   64'd0);
      check("rst_hi",   {32'b0, bus.hi},   64'd0);
      check("rst_lo",   {32'b0, bus.lo},   64'd0);

      // Start accepted on the first edge after release
      rst = 1'b1;
      bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd3; bus.b = 32'd5;
      sb_q.push_back(mk_e(32'd0, 32'd15, 1'b0));
      @(negedge clk);
      bus.start = 1'b0;
      check("first_accept", {63'b0, bus.busy}, 64'd1);
      wait_done(nb);
      check("first_latency", 64'(nb), 64'd32);

      foreach (tbl[i]) begin
         issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e, 1'b1);
         wait_done(nb);
         check({"latency_", tbl[i].name}, 64'(nb), 64'd32);
      end

      for (int i = 0; i < 10; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
         issue(rop, ra, rb, model(rop, ra, rb), 1'b1);
         wait_done(nb);
      end

      // HI/LO hold after done
      repeat (3) @(negedge clk);
      check("hold_hi", {32'b0, bus.hi}, {32'b0, last_hi});
      check("hold_lo", {32'b0, bus.lo}, {32'b0, last_lo});
      check("idle_busy", {63'b0, bus.busy}, 64'd0);

      // Back-to-back: start held in DONE goes straight to CALC
      issue(OP_MULTU, 32'd1000, 32'd1000, mk_e(32'd0, 32'd1000000, 1'b0), 1'b1);
      wait_done(nb);
      bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd1000; bus.b = 32'd33;
      sb_q.push_back(mk_e(32'd10, 32'd30, 1'b0));
      @(negedge clk);
      bus.start = 1'b0;
      check("b2b_busy", {63'b0, bus.busy}, 64'd1);
      wait_done(nb);
      check("b2b_latency", 64'(nb), 64'd32);

      // Start mid-CALC is ignored
      issue(OP_DIVU, 32'd99, 32'd10, mk_e(32'd9, 32'd9, 1'b0), 1'b1);
      repeat (5) @(negedge clk);
      bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd2; bus.b = 32'd2;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(nb);
      check("ignore_latency", 64'(nb), 64'd26);
      count_done(40, nd);
      check("ignore_no_extra_done", 64'(nd), 64'd0);

      // Flush at CALC cycle 10 with simultaneous start
      issue(OP_MULTU, 32'hDEADBEEF, 32'h1234, mk_e(0, 0, 0), 1'b0);
      repeat (9) @(negedge clk);
      bus.flush = 1'b1; bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd50; bus.b = 32'd5;
      @(negedge clk);
      bus.flush = 1'b0; bus.start = 1'b0;
      check("flush_busy", {63'b0, bus.busy}, 64'd0);
      check("flush_done", {63'b0, bus.done}, 64'd0);
      count_done(40, nd);
      check("flush_no_done", 64'(nd), 64'd0);
      check("flush_hi", {32'b0, bus.hi}, {32'b0, last_hi});
      check("flush_lo", {32'b0, bus.lo}, {32'b0, last_lo});

      // Asynchronous reset at CALC cycle 20
      issue(OP_MULTU, 32'hFFFF0000, 32'h00FF00FF, mk_e(0, 0, 0), 1'b0);
      repeat (19) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("arst_busy", {63'b0, bus.busy}, 64'd0);
      check("arst_done", {63'b0, bus.done}, 64'd0);
      check("arst_dz",   {63'b0, bus.dz},   64'd0);
      check("arst_hi",   {32'b0, bus.hi},   64'd0);
      check("arst_lo",   {32'b0, bus.lo},   64'd0);
      @(negedge clk);
      rst = 1'b1;
      bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd6; bus.b = 32'd7;
      sb_q.push_back(mk_e(32'd0, 32'd42, 1'b0));
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(nb);
      check("post_rst_latency", 64'(nb), 64'd32);
      repeat (3) @(negedge clk);

      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
